// File: rtl/uart_pkg.sv
// Shared types for the UART controller: parity modes, FSM states and the RX FIFO entry.
package uart_pkg;
  localparam int MAX_DATA_BITS = 8;

  typedef enum logic [1:0] {NONE = 2'd0, EVEN = 2'd1, ODD = 2'd2} parity_mode_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  typedef struct packed {
    logic [MAX_DATA_BITS-1:0] data;
    logic                     parity_err;
    logic                     frame_err;
  } rx_entry_t;

  // Encoding 3 is reserved and behaves as no parity.
  function automatic logic par_en(input logic [1:0] pm);
    return (pm == EVEN) || (pm == ODD);
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO of received frames; a pop frees a slot for a push in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  rx_entry_t     push_entry,
  input  logic          pop,
  output rx_entry_t     head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [PW:0] wptr, rptr;
  rx_entry_t   mem [DEPTH];
  logic        do_pop, do_push;

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW-1:0] == rptr[PW-1:0]) && (wptr[PW] != rptr[PW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Zero the head when empty so the outputs read 0 after reset.
  assign head    = empty ? '0 : mem[rptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PW-1:0]] <= push_entry;
  end
endmodule

// File: rtl/uart_fifo_controller.sv
// Full-duplex UART: single-frame TX, mid-bit sampled RX feeding a frame FIFO with error flags.
module uart_fifo_controller
  import uart_pkg::*;
#(
  parameter  int FREQ_DIV      = 16,
  parameter  int DATA_BITS     = 8,
  parameter  int RX_FIFO_DEPTH = 8,
  localparam int CNTW          = $clog2(FREQ_DIV),
  localparam int CW            = $clog2(RX_FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 rxd,
  output logic                 txd,
  input  logic [DATA_BITS-1:0] send_data,
  input  logic                 send,
  output logic                 send_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [CW-1:0]        rx_count,
  output logic                 rx_overrun,
  input  logic                 rx_overrun_clr
);
  localparam logic [CNTW-1:0] BIT_END  = CNTW'(FREQ_DIV - 1);
  localparam logic [CNTW-1:0] HALF_END = CNTW'(FREQ_DIV / 2 - 1);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

  // ---------------- TX ----------------
  tx_state_t            tx_state;
  logic [CNTW-1:0]      tx_cnt;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par, tx_two, tx_stop2;
  logic [1:0]           tx_pm;
  logic                 tx_done, tx_accept;

  assign tx_done   = (tx_state == TX_STOP) && (tx_cnt == BIT_END) && (!tx_two || tx_stop2);
  // Accepting on the final stop edge lets back-to-back frames run with no idle gap.
  assign tx_accept = send && ((tx_state == TX_IDLE) || tx_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_two    <= 1'b0;
      tx_stop2  <= 1'b0;
      tx_pm     <= 2'd0;
      txd       <= 1'b1;
      send_busy <= 1'b0;
    end else begin
      tx_cnt <= (tx_state == TX_IDLE || tx_cnt == BIT_END) ? '0 : tx_cnt + 1'b1;
      if (tx_accept) begin
        tx_state  <= TX_START;
        tx_shift  <= send_data;
        tx_par    <= ^send_data;
        tx_pm     <= parity_mode;
        tx_two    <= two_stop;
        tx_stop2  <= 1'b0;
        txd       <= 1'b0;
        send_busy <= 1'b1;
      end else if (tx_state != TX_IDLE && tx_cnt == BIT_END) begin
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
          end
          TX_DATA: begin
            if (tx_bit == LAST_BIT) begin
              if (par_en(tx_pm)) begin
                tx_state <= TX_PARITY;
                txd      <= tx_par ^ (tx_pm == ODD);
              end else begin
                tx_state <= TX_STOP;
                txd      <= 1'b1;
              end
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= tx_shift >> 1;
              txd      <= tx_shift[1];
            end
          end
          TX_PARITY: begin
            tx_state <= TX_STOP;
            txd      <= 1'b1;
          end
          TX_STOP: begin
            if (tx_two && !tx_stop2) begin
              tx_stop2 <= 1'b1;
            end else begin
              tx_state  <= TX_IDLE;
              send_busy <= 1'b0;
              txd       <= 1'b1;
            end
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_t       rx_state;
  logic [CNTW-1:0] rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic [1:0]      rx_pm;
  logic            rx_perr;
  logic            s1, s2, s_prev;
  logic            rx_start, rx_tick, push, pop, full, empty;
  rx_entry_t       push_entry, head;

  assign rx_start   = (rx_state == RX_IDLE) && s_prev && !s2;
  assign rx_tick    = (rx_state == RX_START) ? (rx_cnt == HALF_END) : (rx_cnt == BIT_END);
  assign push       = (rx_state == RX_STOP) && rx_tick;
  assign push_entry = '{data: rx_shift, parity_err: rx_perr, frame_err: ~s2};
  assign pop        = rx_ready && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s1     <= rxd;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_pm    <= 2'd0;
      rx_perr  <= 1'b0;
    end else begin
      rx_cnt <= (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
      case (rx_state)
        RX_IDLE: if (rx_start) begin
          rx_state <= RX_START;
          rx_pm    <= parity_mode;
          rx_shift <= '0;
          rx_perr  <= 1'b0;
          rx_bit   <= '0;
        end
        // A line back high at mid-start is a glitch, not a frame.
        RX_START: if (rx_tick) rx_state <= s2 ? RX_IDLE : RX_DATA;
        RX_DATA: if (rx_tick) begin
          rx_shift[rx_bit] <= s2;
          if (rx_bit == LAST_BIT) rx_state <= par_en(rx_pm) ? RX_PARITY : RX_STOP;
          else                    rx_bit   <= rx_bit + 1'b1;
        end
        RX_PARITY: if (rx_tick) begin
          rx_perr  <= (^rx_shift) ^ s2 ^ (rx_pm == ODD);
          rx_state <= RX_STOP;
        end
        RX_STOP: if (rx_tick) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     rx_overrun <= 1'b0;
    else if (push && full && !pop)  rx_overrun <= 1'b1;
    else if (rx_overrun_clr)        rx_overrun <= 1'b0;
  end

  uart_rx_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (rx_count),
    .full       (full),
    .empty      (empty)
  );

  assign rx_valid      = !empty;
  assign rx_data       = head.data[DATA_BITS-1:0];
  assign rx_parity_err = head.parity_err;
  assign rx_frame_err  = head.frame_err;
endmodule
